// File: rtl/distributor_var_pipe.sv
// Registered 1-to-2 distribution node: one input word fans out to the
// low lane, the high lane or both, with independent per-lane handshakes.
module distributor_var_pipe #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_data_bus,
    input  logic [1:0]              i_dest,
    output logic                    o_ready,
    output logic [1:0]              o_valid,
    output logic [2*DATA_WIDTH-1:0] o_data_bus,
    input  logic [1:0]              i_ready,
    output logic [CNT_WIDTH-1:0]    o_drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        LOW   = 2'b01,
        HIGH  = 2'b10,
        BOTH  = 2'b11
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic [CNT_WIDTH-1:0]  drop_q;
    logic [CNT_WIDTH-1:0]  drop_d;
    logic [1:0]            pend;
    logic [1:0]            stay;
    logic                  accept;
    logic                  drop;

    assign pend    = state_q;
    // Lanes still waiting after this cycle's transfers
    assign stay    = pend & ~i_ready;
    assign o_ready = i_en & (stay == 2'b00);
    assign accept  = i_valid & o_ready;
    assign drop    = accept & (i_dest == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_t'(stay);
        data_d  = data_q;
        drop_d  = drop_q;
        if (accept && !drop) begin
            state_d = state_t'(i_dest);
            data_d  = i_data_bus;
        end
        if (drop && (drop_q != {CNT_WIDTH{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    assign o_valid    = pend;
    assign o_drop_cnt = drop_q;

    always_comb begin
        o_data_bus = '0;
        unique case (state_q)
            LOW:     o_data_bus[DATA_WIDTH-1:0] = data_q;
            HIGH:    o_data_bus[DATA_WIDTH+:DATA_WIDTH] = data_q;
            BOTH:    o_data_bus = {data_q, data_q};
            default: o_data_bus = '0;
        endcase
    end

endmodule

// File: tb/tb_distributor_var_pipe.sv
// Self-checking bench: directed scenarios plus random traffic against a
// per-lane behavioural model of the distribution node.
module tb_distributor_var_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_en;
    logic       i_valid;
    logic [3:0] i_data_bus;
    logic [1:0] i_dest;
    logic       o_ready;
    logic [1:0] o_valid;
    logic [7:0] o_data_bus;
    logic [1:0] i_ready;
    logic [7:0] o_drop_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: each lane is an independent slot holding its own copy
    bit       mv [2];
    bit [3:0] md [2];
    int       mcnt;

    always #5 clk = ~clk;

    distributor_var_pipe #(.DATA_WIDTH(4), .CNT_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .i_dest     (i_dest),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .i_ready    (i_ready),
        .o_drop_cnt (o_drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        bit blocked;
        blocked = 1'b0;
        for (int k = 0; k < 2; k++)
            if (mv[k] && !i_ready[k]) blocked = 1'b1;
        return i_en && !blocked;
    endfunction

    function automatic logic [1:0] exp_valid();
        return {mv[1], mv[0]};
    endfunction

    function automatic logic [7:0] exp_data();
        logic [3:0] lo;
        logic [3:0] hi;
        lo = mv[0] ? md[0] : 4'h0;
        hi = mv[1] ? md[1] : 4'h0;
        return {hi, lo};
    endfunction

    // Drives one cycle; called at posedge+1, returns at next posedge+1
    task automatic step(input bit r, input bit en, input bit v,
                        input logic [3:0] d, input logic [1:0] dst,
                        input logic [1:0] rdy, input string tag);
        bit acc;
        rst        = r;
        i_en       = en;
        i_valid    = v;
        i_data_bus = d;
        i_dest     = dst;
        i_ready    = rdy;
        #1;
        check({tag, ".ready"}, o_ready, model_ready());
        acc = v && model_ready();
        @(posedge clk);
        if (r) begin
            mv[0] = 0; mv[1] = 0; md[0] = 0; md[1] = 0; mcnt = 0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (mv[k] && rdy[k]) mv[k] = 0;
            if (acc) begin
                if (dst == 2'b00) begin
                    if (mcnt < 255) mcnt++;
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        mv[k] = dst[k];
                        if (dst[k]) md[k] = d;
                    end
                end
            end
        end
        #1;
        check({tag, ".valid"}, o_valid, exp_valid());
        check({tag, ".data"}, o_data_bus, exp_data());
        check({tag, ".cnt"}, o_drop_cnt, mcnt);
    endtask

    initial begin
        rst = 1; i_en = 1; i_valid = 1; i_data_bus = 4'hF;
        i_dest = 2'b11; i_ready = 2'b00;
        mv[0] = 0; mv[1] = 0; md[0] = 0; md[1] = 0; mcnt = 0;
        @(posedge clk); #1;

        // Reset with valid asserted
        step(1, 1, 1, 4'h7, 2'b11, 2'b00, "rst0");
        step(1, 1, 1, 4'h7, 2'b11, 2'b00, "rst1");
        check("rst.valid", o_valid, 2'b00);
        check("rst.data", o_data_bus, 8'h00);
        check("rst.cnt", o_drop_cnt, 8'h00);
        i_en = 1; rst = 0; i_valid = 0; #1;
        check("rst.ready", o_ready, 1'b1);

        // Unicast low
        step(0, 1, 1, 4'hA, 2'b01, 2'b11, "uni");
        check("uni.out", {o_valid, o_data_bus}, {2'b01, 8'h0A});
        step(0, 1, 0, 4'h0, 2'b00, 2'b11, "uni_clr");
        check("uni.clr", o_valid, 2'b00);

        // Multicast with a stalled high lane
        step(0, 1, 1, 4'h5, 2'b11, 2'b01, "mc");
        check("mc.both", {o_valid, o_data_bus}, {2'b11, 8'h55});
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 4'h9, 2'b01, 2'b01, "mc_stall");
            check("mc.hold", {o_valid, o_data_bus}, {2'b10, 8'h50});
        end
        check("mc.noready", o_ready, 1'b0);
        step(0, 1, 0, 4'h0, 2'b00, 2'b11, "mc_drain");
        check("mc.empty", o_valid, 2'b00);

        // Back-to-back
        step(0, 1, 1, 4'h1, 2'b01, 2'b11, "b2b1");
        check("b2b1.out", {o_valid, o_data_bus}, {2'b01, 8'h01});
        step(0, 1, 1, 4'h2, 2'b10, 2'b11, "b2b2");
        check("b2b2.out", {o_valid, o_data_bus}, {2'b10, 8'h20});
        step(0, 1, 1, 4'h3, 2'b11, 2'b11, "b2b3");
        check("b2b3.out", {o_valid, o_data_bus}, {2'b11, 8'h33});
        step(0, 1, 1, 4'h4, 2'b01, 2'b11, "b2b4");
        check("b2b4.out", {o_valid, o_data_bus}, {2'b01, 8'h04});
        step(0, 1, 0, 4'h0, 2'b00, 2'b11, "b2b_end");

        // Enable low blocks acceptance
        step(0, 0, 1, 4'hC, 2'b01, 2'b11, "en0");
        check("en0.ready", o_ready, 1'b0);
        check("en0.valid", o_valid, 2'b00);

        // Drop counter saturation
        for (int i = 0; i < 300; i++)
            step(0, 1, 1, 4'(i), 2'b00, 2'b11, "drop");
        check("drop.sat", o_drop_cnt, 8'hFF);
        check("drop.valid", o_valid, 2'b00);

        // Reset mid-operation
        step(0, 1, 1, 4'hE, 2'b11, 2'b00, "mid_load");
        step(1, 1, 0, 4'h0, 2'b00, 2'b00, "mid_rst");
        check("mid.valid", o_valid, 2'b00);
        check("mid.cnt", o_drop_cnt, 8'h00);
        step(0, 1, 0, 4'h0, 2'b00, 2'b11, "mid_after");
        check("mid.stale", {o_valid, o_data_bus}, 10'h000);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(0, ($urandom_range(0, 7) != 0), 1'($urandom),
                 4'($urandom), 2'($urandom), 2'($urandom), "rnd");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
